// File: rtl/n64_vbus_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : n64_vbus_gen_pkg
// Description : Shared widths, default timing, sync-nibble bit positions and
//               pattern encodings for the N64 video-bus generator.
// Revision    : 1.0 - initial release
// ============================================================================
package n64_vbus_gen_pkg;

  // Counter and data widths, sized for the largest standard timing
  localparam int unsigned H_W  = 10;
  localparam int unsigned V_W  = 9;
  localparam int unsigned C_W  = 7;
  localparam int unsigned BP_W = 8;

  // Default timing (odd-field line counts; even fields are one line shorter)
  localparam int unsigned H_TOTAL_DEF      = 773;
  localparam int unsigned H_SYNC_DEF       = 57;
  localparam int unsigned H_CLAMP_DEF      = 16;
  localparam int unsigned H_ACT_START_DEF  = 108;
  localparam int unsigned BAR_W_DEF        = 80;
  localparam int unsigned V_SYNC_DEF       = 3;
  localparam int unsigned V_ACT_START_DEF  = 20;
  localparam int unsigned V_ACT_DEF        = 240;
  localparam int unsigned V_TOTAL_NTSC_DEF = 263;
  localparam int unsigned V_TOTAL_PAL_DEF  = 313;

  // Bit positions of the sync nibble inside D[3:0]
  localparam int unsigned SYNC_VSYNC = 3;
  localparam int unsigned SYNC_CLAMP = 2;
  localparam int unsigned SYNC_HSYNC = 1;
  localparam int unsigned SYNC_CSYNC = 0;

  typedef enum logic {
    PAT_BARS = 1'b0,
    PAT_RAMP = 1'b1
  } pat_e;

  typedef enum logic [1:0] {
    SLOT_SYNC = 2'd0,
    SLOT_R    = 2'd1,
    SLOT_G    = 2'd2,
    SLOT_B    = 2'd3
  } slot_e;

  // Assemble the sync word: upper three bits are always high on the bus
  function automatic logic [C_W-1:0] sync_word(input logic nvs, input logic ncl,
                                               input logic nhs, input logic ncs);
    logic [C_W-1:0] w;
    w             = 7'b111_0000;
    w[SYNC_VSYNC] = nvs;
    w[SYNC_CLAMP] = ncl;
    w[SYNC_HSYNC] = nhs;
    w[SYNC_CSYNC] = ncs;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/n64_vbus_gen_timing.sv
`default_nettype none
// ============================================================================
// Module      : n64_vbus_gen_timing
// Description : Slot/pixel/line counters, field parity, mode latches and
//               sync-nibble generation for the N64 video bus.
// Revision    : 1.0 - initial release
// ============================================================================
module n64_vbus_gen_timing
  import n64_vbus_gen_pkg::*;
#(
  parameter int unsigned H_TOTAL      = H_TOTAL_DEF,
  parameter int unsigned H_SYNC       = H_SYNC_DEF,
  parameter int unsigned H_CLAMP      = H_CLAMP_DEF,
  parameter int unsigned H_ACT_START  = H_ACT_START_DEF,
  parameter int unsigned H_ACT        = 8 * BAR_W_DEF,
  parameter int unsigned V_SYNC       = V_SYNC_DEF,
  parameter int unsigned V_ACT_START  = V_ACT_START_DEF,
  parameter int unsigned V_ACT        = V_ACT_DEF,
  parameter int unsigned V_TOTAL_NTSC = V_TOTAL_NTSC_DEF,
  parameter int unsigned V_TOTAL_PAL  = V_TOTAL_PAL_DEF
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           vmode_i,
  input  logic           n64_480i_i,
  output slot_e          slot_o,
  output logic [H_W-1:0] h_o,
  output logic [V_W-1:0] v_o,
  output logic           active_o,
  output logic           field_start_o,
  output logic           field_odd_o,
  output logic           nvsync_o,
  output logic           nclamp_o,
  output logic           nhsync_o,
  output logic           ncsync_o
);

  localparam logic [H_W-1:0] H_LAST    = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_HALF    = H_W'(H_TOTAL / 2);
  localparam logic [H_W-1:0] H_SYNC_L  = H_W'(H_SYNC);
  localparam logic [H_W-1:0] H_CL_END  = H_W'(H_SYNC + H_CLAMP);
  localparam logic [H_W-1:0] H_ACT_B   = H_W'(H_ACT_START);
  localparam logic [H_W-1:0] H_ACT_E   = H_W'(H_ACT_START + H_ACT);
  localparam logic [V_W-1:0] V_SYNC_L  = V_W'(V_SYNC);
  localparam logic [V_W-1:0] V_ACT_B   = V_W'(V_ACT_START);
  localparam logic [V_W-1:0] V_ACT_E   = V_W'(V_ACT_START + V_ACT);
  localparam logic [V_W-1:0] V_NTSC_O  = V_W'(V_TOTAL_NTSC - 1);
  localparam logic [V_W-1:0] V_NTSC_E  = V_W'(V_TOTAL_NTSC - 2);
  localparam logic [V_W-1:0] V_PAL_O   = V_W'(V_TOTAL_PAL - 1);
  localparam logic [V_W-1:0] V_PAL_E   = V_W'(V_TOTAL_PAL - 2);

  slot_e          slot_q, slot_d;
  logic [H_W-1:0] h_q, h_d;
  logic [V_W-1:0] v_q, v_d;
  logic           odd_q, odd_d;
  logic           vmode_q, vmode_d;
  logic           i480_q, i480_d;

  logic           field_start;
  logic           odd_cur;
  logic [V_W-1:0] v_last;
  logic           vs_odd, vs_even, nvs, nhs;

  // A field that starts while 240p is selected is always odd, which also
  // covers the 480i -> 240p switch.
  assign field_start = (slot_q == SLOT_SYNC) && (h_q == '0) && (v_q == '0);
  assign odd_cur     = field_start ? (odd_q | ~n64_480i_i) : odd_q;

  assign v_last = vmode_q ? (odd_cur ? V_PAL_O  : V_PAL_E)
                          : (odd_cur ? V_NTSC_O : V_NTSC_E);

  // Next-state for the slot/pixel/line counters, parity and mode latches
  always_comb begin
    slot_d  = slot_e'(slot_q + 2'd1);
    h_d     = h_q;
    v_d     = v_q;
    odd_d   = odd_cur;
    vmode_d = vmode_q;
    i480_d  = i480_q;
    if (field_start) begin
      vmode_d = vmode_i;
      i480_d  = n64_480i_i;
    end
    if (slot_q == SLOT_B) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        if (v_q == v_last) begin
          v_d   = '0;
          odd_d = i480_q ? ~odd_cur : 1'b1;
        end else begin
          v_d = v_q + 1'b1;
        end
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // Counter state register; reset restarts at the top of an odd field
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_q  <= SLOT_SYNC;
      h_q     <= '0;
      v_q     <= '0;
      odd_q   <= 1'b1;
      vmode_q <= 1'b0;
      i480_q  <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      h_q     <= h_d;
      v_q     <= v_d;
      odd_q   <= odd_d;
      vmode_q <= vmode_d;
      i480_q  <= i480_d;
    end
  end

  // Even-field vsync is offset by half a line so it never lines up with hsync
  assign vs_odd  = (v_q < V_SYNC_L);
  assign vs_even = ((v_q == '0) && (h_q >= H_HALF)) ||
                   ((v_q != '0) && (v_q < V_SYNC_L)) ||
                   ((v_q == V_SYNC_L) && (h_q < H_HALF));
  assign nvs     = ~(odd_cur ? vs_odd : vs_even);
  assign nhs     = ~(h_q < H_SYNC_L);

  assign nvsync_o      = nvs;
  assign nhsync_o      = nhs;
  assign ncsync_o      = nvs ? nhs : ~nhs;
  assign nclamp_o      = ~((h_q >= H_SYNC_L) && (h_q < H_CL_END) && nvs);
  assign active_o      = (v_q >= V_ACT_B) && (v_q < V_ACT_E) &&
                         (h_q >= H_ACT_B) && (h_q < H_ACT_E);
  assign slot_o        = slot_q;
  assign h_o           = h_q;
  assign v_o           = v_q;
  assign field_start_o = field_start;
  assign field_odd_o   = odd_cur;

endmodule
`default_nettype wire

// File: rtl/n64_vbus_gen.sv
`default_nettype none
// ============================================================================
// Module      : n64_vbus_gen
// Description : N64 multiplexed video-bus generator (nDSYNC + D[6:0]) with
//               colour-bar / grey-ramp test patterns.
// Revision    : 1.0 - initial release
// ============================================================================
module n64_vbus_gen
  import n64_vbus_gen_pkg::*;
#(
  parameter int unsigned H_TOTAL      = H_TOTAL_DEF,
  parameter int unsigned H_SYNC       = H_SYNC_DEF,
  parameter int unsigned H_CLAMP      = H_CLAMP_DEF,
  parameter int unsigned H_ACT_START  = H_ACT_START_DEF,
  parameter int unsigned BAR_W        = BAR_W_DEF,
  parameter int unsigned V_SYNC       = V_SYNC_DEF,
  parameter int unsigned V_ACT_START  = V_ACT_START_DEF,
  parameter int unsigned V_ACT        = V_ACT_DEF,
  parameter int unsigned V_TOTAL_NTSC = V_TOTAL_NTSC_DEF,
  parameter int unsigned V_TOTAL_PAL  = V_TOTAL_PAL_DEF
) (
  input  logic           VCLK,
  input  logic           RST,
  input  logic           vmode_i,
  input  logic           n64_480i_i,
  input  logic           pat_sel_i,
  output logic           nDSYNC,
  output logic [C_W-1:0] D_o,
  output logic           frame_id_o
);

  // Last pixel before the first active one; wraps when activity starts at h=0
  localparam int unsigned   BAR_RST_I = (H_ACT_START == 0) ? H_TOTAL - 1 : H_ACT_START - 1;
  localparam logic [H_W-1:0] BAR_RST_H = H_W'(BAR_RST_I);
  localparam logic [H_W-1:0] H_ACT_B   = H_W'(H_ACT_START);
  localparam logic [BP_W-1:0] BAR_LAST = BP_W'(BAR_W - 1);

  slot_e          slot;
  logic [H_W-1:0] h;
  logic [V_W-1:0] v;
  logic           active, field_start, field_odd;
  logic           nvs, ncl, nhs, ncs;

  n64_vbus_gen_timing #(
    .H_TOTAL      (H_TOTAL),
    .H_SYNC       (H_SYNC),
    .H_CLAMP      (H_CLAMP),
    .H_ACT_START  (H_ACT_START),
    .H_ACT        (8 * BAR_W),
    .V_SYNC       (V_SYNC),
    .V_ACT_START  (V_ACT_START),
    .V_ACT        (V_ACT),
    .V_TOTAL_NTSC (V_TOTAL_NTSC),
    .V_TOTAL_PAL  (V_TOTAL_PAL)
  ) u_timing (
    .clk_i         (VCLK),
    .rst_i         (RST),
    .vmode_i       (vmode_i),
    .n64_480i_i    (n64_480i_i),
    .slot_o        (slot),
    .h_o           (h),
    .v_o           (v),
    .active_o      (active),
    .field_start_o (field_start),
    .field_odd_o   (field_odd),
    .nvsync_o      (nvs),
    .nclamp_o      (ncl),
    .nhsync_o      (nhs),
    .ncsync_o      (ncs)
  );

  pat_e            pat_q, pat_d;
  logic [BP_W-1:0] bar_px_q, bar_px_d;
  logic [2:0]      bar_idx_q, bar_idx_d;
  logic            ndsync_q, ndsync_d;
  logic [C_W-1:0]  d_q, d_d;
  logic            fid_q, fid_d;

  logic [H_W-1:0]  ramp_off;
  logic [C_W-1:0]  col_r, col_g, col_b;
  logic            unused_ramp_bits;

  assign ramp_off         = h - H_ACT_B;
  assign unused_ramp_bits = ^{ramp_off[H_W-1], ramp_off[1:0]};

  // Pattern colour for the pixel currently addressed by the counters
  always_comb begin
    col_r = '0;
    col_g = '0;
    col_b = '0;
    if (active) begin
      if (pat_q == PAT_RAMP) begin
        col_r = ramp_off[8:2];
        col_g = ramp_off[8:2];
        col_b = ramp_off[8:2];
      end else begin
        col_r = bar_idx_q[1] ? 7'h00 : 7'h7F;
        col_g = bar_idx_q[2] ? 7'h00 : 7'h7F;
        col_b = bar_idx_q[0] ? 7'h00 : 7'h7F;
      end
    end
  end

  // Next-state for pattern latch, bar sub-counter and the output word
  always_comb begin
    pat_d     = pat_q;
    bar_px_d  = bar_px_q;
    bar_idx_d = bar_idx_q;
    ndsync_d  = 1'b1;
    d_d       = '0;
    fid_d     = field_start ? field_odd : fid_q;
    if ((slot == SLOT_SYNC) && (h == '0)) begin
      pat_d = pat_e'(pat_sel_i);
    end
    if (slot == SLOT_B) begin
      if (h == BAR_RST_H) begin
        bar_px_d  = '0;
        bar_idx_d = '0;
      end else if (bar_px_q == BAR_LAST) begin
        bar_px_d  = '0;
        bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_px_d  = bar_px_q + 1'b1;
      end
    end
    case (slot)
      SLOT_SYNC: begin
        ndsync_d = 1'b0;
        d_d      = sync_word(nvs, ncl, nhs, ncs);
      end
      SLOT_R:  d_d = col_r;
      SLOT_G:  d_d = col_g;
      default: d_d = col_b;
    endcase
  end

  // Output and pattern-state registers
  always_ff @(posedge VCLK or posedge RST) begin
    if (RST) begin
      pat_q     <= PAT_BARS;
      bar_px_q  <= '0;
      bar_idx_q <= '0;
      ndsync_q  <= 1'b1;
      d_q       <= '0;
      fid_q     <= 1'b1;
    end else begin
      pat_q     <= pat_d;
      bar_px_q  <= bar_px_d;
      bar_idx_q <= bar_idx_d;
      ndsync_q  <= ndsync_d;
      d_q       <= d_d;
      fid_q     <= fid_d;
    end
  end

  assign nDSYNC     = ndsync_q;
  assign D_o        = d_q;
  assign frame_id_o = fid_q;

endmodule
`default_nettype wire

// File: tb/tb_n64_vbus_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_n64_vbus_gen
// Description : Self-checking bench for n64_vbus_gen using shrunken timing
//               (65 px/line, NTSC 23/22, PAL 25/24 lines) to keep runs short.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_n64_vbus_gen;

  localparam int HT   = 65;   // pixels per line
  localparam int LINE = HT * 4;

  logic       vclk = 1'b0;
  logic       rst;
  logic       vmode, i480, pat_sel;
  logic       ndsync;
  logic [6:0] d;
  logic       fid;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int pos   = 0;

  always #5 vclk = ~vclk;

  n64_vbus_gen #(
    .H_TOTAL      (HT),
    .H_SYNC       (5),
    .H_CLAMP      (3),
    .H_ACT_START  (10),
    .BAR_W        (6),
    .V_SYNC       (3),
    .V_ACT_START  (4),
    .V_ACT        (10),
    .V_TOTAL_NTSC (23),
    .V_TOTAL_PAL  (25)
  ) dut (
    .VCLK       (vclk),
    .RST        (rst),
    .vmode_i    (vmode),
    .n64_480i_i (i480),
    .pat_sel_i  (pat_sel),
    .nDSYNC     (ndsync),
    .D_o        (d),
    .frame_id_o (fid)
  );

  typedef struct {
    int         v;
    int         h;
    int         s;
    logic       pat;
    logic       nds;
    logic [6:0] dat;
  } vec_t;

  typedef struct {
    int         idx;
    logic       nds;
    logic [6:0] dat;
  } exp_t;

  typedef struct {
    int   at;
    logic nh;
    logic fid;
  } fall_t;

  vec_t  tbl[$];
  exp_t  sb[$];
  fall_t fall_q[$];
  logic  last_vs;

  always @(posedge vclk) cyc <= cyc + 1;

  // Records every nVSYNC fall seen in a sync slot, with hsync and parity
  always @(negedge vclk) begin
    if (rst) begin
      last_vs <= 1'b1;
    end else if (!ndsync) begin
      if (last_vs && !d[3]) fall_q.push_back('{cyc, d[1], fid});
      last_vs <= d[3];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input int v, input int h, input int s, input logic p,
                     input logic nds, input logic [6:0] dat);
    tbl.push_back('{v, h, s, p, nds, dat});
  endtask

  task automatic step();
    @(posedge vclk);
    pos++;
  endtask

  task automatic wait_fall(output fall_t f);
    f = '{0, 1'bx, 1'bx};
    for (int i = 0; i < 8000 && fall_q.size() == 0; i++) @(posedge vclk);
    if (fall_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL vsync_fall_timeout: got none, expected a fall within 8000 cycles");
    end else begin
      f = fall_q.pop_front();
    end
  endtask

  fall_t f0, f1, f2, f3, f4, f5, fr;

  initial begin
    rst = 1'b1; vmode = 1'b0; i480 = 1'b0; pat_sel = 1'b0;

    // Sync words: odd-field vsync (0x75/0x76), clamp, plain line start 0x7C
    add(0, 0, 0, 0, 0, 7'h75);
    add(0, 0, 1, 0, 1, 7'h00);
    add(0, 5, 0, 0, 0, 7'h76);
    add(2, 64, 0, 0, 0, 7'h76);
    add(3, 0, 0, 0, 0, 7'h7C);
    add(3, 5, 0, 0, 0, 7'h7B);
    add(3, 8, 0, 0, 0, 7'h7F);
    add(3, 20, 1, 0, 1, 7'h00);
    // Colour bars on the first active line
    add(4, 9, 1, 0, 1, 7'h00);
    add(4, 10, 1, 0, 1, 7'h7F);
    add(4, 10, 2, 0, 1, 7'h7F);
    add(4, 10, 3, 0, 1, 7'h7F);
    add(4, 16, 1, 0, 1, 7'h7F);
    add(4, 16, 3, 0, 1, 7'h00);
    add(4, 22, 1, 0, 1, 7'h00);
    add(4, 22, 2, 0, 1, 7'h7F);
    add(4, 22, 3, 0, 1, 7'h7F);
    add(4, 40, 1, 0, 1, 7'h7F);
    add(4, 40, 2, 0, 1, 7'h00);
    add(4, 52, 2, 0, 1, 7'h00);
    add(4, 58, 1, 0, 1, 7'h00);
    // Grey ramp from the next line on
    add(5, 0, 0, 1, 0, 7'h7C);
    add(5, 10, 1, 1, 1, 7'h00);
    add(5, 22, 1, 1, 1, 7'h03);
    add(5, 22, 2, 1, 1, 7'h03);
    add(5, 22, 3, 1, 1, 7'h03);
    add(5, 57, 2, 1, 1, 7'h0B);
    add(13, 57, 3, 1, 1, 7'h0B);
    add(14, 22, 1, 1, 1, 7'h00);

    repeat (3) @(negedge vclk);
    check("reset_ndsync", ndsync, 1'b1);
    check("reset_d", d, 7'h00);
    check("reset_frame_id", fid, 1'b1);
    rst = 1'b0;
    pos = 0;

    foreach (tbl[e]) begin
      int target;
      pat_sel = tbl[e].pat;
      target  = ((tbl[e].v * HT) + tbl[e].h) * 4 + tbl[e].s;
      while (pos < target) step();
      sb.push_back('{e, tbl[e].nds, tbl[e].dat});
      step();
      #1;
      begin
        exp_t x;
        x = sb.pop_front();
        check($sformatf("vec%0d_ndsync", x.idx), ndsync, x.nds);
        check($sformatf("vec%0d_d", x.idx), d, x.dat);
        check($sformatf("vec%0d_frame_id", x.idx), fid, 1'b1);
      end
    end

    // Field timing: NTSC 240p, then NTSC->PAL 480i mid-field, then back to 240p
    wait_fall(f0);
    check("f0_hsync_coincident", f0.nh, 1'b0);
    check("f0_frame_id", f0.fid, 1'b1);
    wait_fall(f1);
    check("f1_ntsc240p_len", f1.at - f0.at, 23 * LINE);
    check("f1_hsync_coincident", f1.nh, 1'b0);
    check("f1_frame_id", f1.fid, 1'b1);
    vmode = 1'b1;
    i480  = 1'b1;
    wait_fall(f2);
    check("f2_midfield_switch_ntsc_len", f2.at - f1.at, 23 * LINE);
    check("f2_frame_id", f2.fid, 1'b1);
    wait_fall(f3);
    check("f3_pal_odd_to_even_fall", f3.at - f2.at, 25 * LINE + (HT / 2) * 4);
    check("f3_even_hsync_high", f3.nh, 1'b1);
    check("f3_even_frame_id", f3.fid, 1'b0);
    wait_fall(f4);
    check("f4_pal_even_to_odd_fall", f4.at - f3.at, 24 * LINE - (HT / 2) * 4);
    check("f4_hsync_coincident", f4.nh, 1'b0);
    check("f4_frame_id", f4.fid, 1'b1);
    i480 = 1'b0;
    wait_fall(f5);
    check("f5_forced_odd_len", f5.at - f4.at, 25 * LINE);
    check("f5_hsync_coincident", f5.nh, 1'b0);
    check("f5_frame_id", f5.fid, 1'b1);

    // Reset mid-line while a sync word is on the bus
    repeat (10 * LINE + 30 * 4) @(negedge vclk);
    for (int i = 0; i < 8 && ndsync !== 1'b0; i++) @(negedge vclk);
    check("pre_reset_sync_slot", ndsync, 1'b0);
    rst = 1'b1;
    #1;
    check("async_reset_ndsync", ndsync, 1'b1);
    check("async_reset_d", d, 7'h00);
    check("async_reset_frame_id", fid, 1'b1);
    repeat (2) @(negedge vclk);
    fall_q.delete();
    rst = 1'b0;
    @(posedge vclk);
    #1;
    check("post_reset_first_ndsync", ndsync, 1'b0);
    check("post_reset_first_word", d, 7'h75);
    wait_fall(fr);
    check("post_reset_hsync_coincident", fr.nh, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
